// File: rtl/hazard_ctrl.sv
// Stall, flush and operand-forwarding control for the 5-stage RV32I pipeline.
// Defining HAZARD_PERF_EN adds saturating stall/flush cycle counters (stall_cnt_o, flush_cnt_o).
module hazard_ctrl #(
    parameter int LOAD_LAT = 2
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [4:0] id_rs1_addr_i,
    input  logic [4:0] id_rs2_addr_i,
    input  logic       id_is_rs2_i,
    input  logic [4:0] ex_rs1_addr_i,
    input  logic [4:0] ex_rs2_addr_i,
    input  logic [4:0] ex_rd_addr_i,
    input  logic       ex_rd_wren_i,
    input  logic       ex_is_load_i,
    input  logic       ex_br_taken_i,
    input  logic [4:0] mem_rd_addr_i,
    input  logic       mem_rd_wren_i,
    input  logic [4:0] wb_rd_addr_i,
    input  logic       wb_rd_wren_i,
    input  logic       mem_req_i,
    input  logic       mem_ready_i,
    output logic       pc_en_o,
    output logic       id_en_o,
    output logic       ex_en_o,
    output logic       mem_en_o,
    output logic       id_flush_o,
    output logic       ex_flush_o,
    output logic [1:0] fwd_a_sel_o,
    output logic [1:0] fwd_b_sel_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    // The detection cycle already stalls combinationally, so LD_STALL covers the rest.
    localparam logic [1:0] LD_REMAIN = 2'(LOAD_LAT - 1);

    state_t     r_state;
    logic [1:0] r_cnt;
    logic       r_ret;

    logic       w_load_use;
    logic       w_mem_block;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] mem_rd,
        input logic       mem_we,
        input logic [4:0] wb_rd,
        input logic       wb_we
    );
        if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs))
            return 2'b01;
        if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs))
            return 2'b10;
        return 2'b00;
    endfunction

    assign w_load_use = ex_is_load_i && ex_rd_wren_i && (ex_rd_addr_i != 5'd0) &&
                        ((ex_rd_addr_i == id_rs1_addr_i) ||
                         (id_is_rs2_i && (ex_rd_addr_i == id_rs2_addr_i)));
    assign w_mem_block = mem_req_i && !mem_ready_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= RUN;
            r_cnt   <= 2'd0;
            r_ret   <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_mem_block) begin
                        r_state <= MEM_WAIT;
                        r_ret   <= 1'b0;
                    end else if (!ex_br_taken_i && w_load_use && (LD_REMAIN != 2'd0)) begin
                        r_state <= LD_STALL;
                        r_cnt   <= LD_REMAIN;
                    end
                end
                LD_STALL: begin
                    // A memory wait freezes the bubble count until the access completes.
                    if (w_mem_block) begin
                        r_state <= MEM_WAIT;
                        r_ret   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                        if (r_cnt <= 2'd1)
                            r_state <= RUN;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready_i)
                        r_state <= r_ret ? LD_STALL : RUN;
                end
                default: r_state <= RUN;
            endcase
        end
    end

    always_comb begin
        pc_en_o     = 1'b1;
        id_en_o     = 1'b1;
        ex_en_o     = 1'b1;
        mem_en_o    = 1'b1;
        id_flush_o  = 1'b0;
        ex_flush_o  = 1'b0;
        fwd_a_sel_o = fwd_sel(ex_rs1_addr_i, mem_rd_addr_i, mem_rd_wren_i,
                              wb_rd_addr_i, wb_rd_wren_i);
        fwd_b_sel_o = fwd_sel(ex_rs2_addr_i, mem_rd_addr_i, mem_rd_wren_i,
                              wb_rd_addr_i, wb_rd_wren_i);
        if (reset_i) begin
            pc_en_o     = 1'b0;
            id_en_o     = 1'b0;
            ex_en_o     = 1'b0;
            mem_en_o    = 1'b0;
            id_flush_o  = 1'b1;
            ex_flush_o  = 1'b1;
            fwd_a_sel_o = 2'b00;
            fwd_b_sel_o = 2'b00;
        end else begin
            case (r_state)
                RUN: begin
                    if (ex_br_taken_i) begin
                        id_flush_o = 1'b1;
                        ex_flush_o = 1'b1;
                    end else if (w_load_use) begin
                        pc_en_o    = 1'b0;
                        id_en_o    = 1'b0;
                        ex_flush_o = 1'b1;
                    end
                end
                LD_STALL: begin
                    pc_en_o    = 1'b0;
                    id_en_o    = 1'b0;
                    ex_flush_o = 1'b1;
                end
                MEM_WAIT: begin
                    pc_en_o  = 1'b0;
                    id_en_o  = 1'b0;
                    ex_en_o  = 1'b0;
                    mem_en_o = 1'b0;
                end
                default: begin
                    pc_en_o = 1'b1;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;
    logic        w_flush_evt;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign w_flush_evt = (r_state == RUN) && ex_br_taken_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (!pc_en_o)
                r_stall_cnt <= sat_inc(r_stall_cnt);
            if (w_flush_evt)
                r_flush_cnt <= sat_inc(r_flush_cnt);
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a cycle-level reference model predicts every output,
// a separate monitor compares. Perf-counter checks are compiled in with HAZARD_PERF_EN.
module tb_hazard_ctrl;

    localparam int LOAD_LAT = 2;

    logic       clk = 1'b0;
    logic       reset_i;
    logic [4:0] id_rs1_addr_i, id_rs2_addr_i;
    logic       id_is_rs2_i;
    logic [4:0] ex_rs1_addr_i, ex_rs2_addr_i, ex_rd_addr_i;
    logic       ex_rd_wren_i, ex_is_load_i, ex_br_taken_i;
    logic [4:0] mem_rd_addr_i;
    logic       mem_rd_wren_i;
    logic [4:0] wb_rd_addr_i;
    logic       wb_rd_wren_i;
    logic       mem_req_i, mem_ready_i;
    logic       pc_en_o, id_en_o, ex_en_o, mem_en_o;
    logic       id_flush_o, ex_flush_o;
    logic [1:0] fwd_a_sel_o, fwd_b_sel_o;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_LAT(LOAD_LAT)) dut (
        .clk_i(clk),
        .reset_i(reset_i),
        .id_rs1_addr_i(id_rs1_addr_i),
        .id_rs2_addr_i(id_rs2_addr_i),
        .id_is_rs2_i(id_is_rs2_i),
        .ex_rs1_addr_i(ex_rs1_addr_i),
        .ex_rs2_addr_i(ex_rs2_addr_i),
        .ex_rd_addr_i(ex_rd_addr_i),
        .ex_rd_wren_i(ex_rd_wren_i),
        .ex_is_load_i(ex_is_load_i),
        .ex_br_taken_i(ex_br_taken_i),
        .mem_rd_addr_i(mem_rd_addr_i),
        .mem_rd_wren_i(mem_rd_wren_i),
        .wb_rd_addr_i(wb_rd_addr_i),
        .wb_rd_wren_i(wb_rd_wren_i),
        .mem_req_i(mem_req_i),
        .mem_ready_i(mem_ready_i),
        .pc_en_o(pc_en_o),
        .id_en_o(id_en_o),
        .ex_en_o(ex_en_o),
        .mem_en_o(mem_en_o),
        .id_flush_o(id_flush_o),
        .ex_flush_o(ex_flush_o),
        .fwd_a_sel_o(fwd_a_sel_o),
        .fwd_b_sel_o(fwd_b_sel_o)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt_o(stall_cnt_o),
        .flush_cnt_o(flush_cnt_o)
`endif
    );

    typedef struct packed {
        logic [4:0] id_rs1;
        logic [4:0] id_rs2;
        logic       id_is_rs2;
        logic [4:0] ex_rs1;
        logic [4:0] ex_rs2;
        logic [4:0] ex_rd;
        logic       ex_we;
        logic       ex_ld;
        logic       br;
        logic [4:0] mem_rd;
        logic       mem_we;
        logic [4:0] wb_rd;
        logic       wb_we;
        logic       req;
        logic       rdy;
    } stim_t;

    typedef struct {
        logic [3:0]  en;   // {pc, id, ex, mem}
        logic [1:0]  fl;   // {id_flush, ex_flush}
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   pushed = 0;
    int   popped = 0;

    // Reference model: "waiting" on memory, plus the number of further stall cycles owed.
    bit          m_wait = 1'b0;
    int          m_owed = 0;
    logic [31:0] m_sc = 32'd0;
    logic [31:0] m_fc = 32'd0;

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input stim_t s);
        if (rs == 5'd0) return 2'b00;
        if (s.mem_we && s.mem_rd == rs) return 2'b01;
        if (s.wb_we && s.wb_rd == rs) return 2'b10;
        return 2'b00;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input stim_t s, input bit rst);
        exp_t e;
        bit   lu;
        @(negedge clk);
        reset_i       = rst;
        id_rs1_addr_i = s.id_rs1;
        id_rs2_addr_i = s.id_rs2;
        id_is_rs2_i   = s.id_is_rs2;
        ex_rs1_addr_i = s.ex_rs1;
        ex_rs2_addr_i = s.ex_rs2;
        ex_rd_addr_i  = s.ex_rd;
        ex_rd_wren_i  = s.ex_we;
        ex_is_load_i  = s.ex_ld;
        ex_br_taken_i = s.br;
        mem_rd_addr_i = s.mem_rd;
        mem_rd_wren_i = s.mem_we;
        wb_rd_addr_i  = s.wb_rd;
        wb_rd_wren_i  = s.wb_we;
        mem_req_i     = s.req;
        mem_ready_i   = s.rdy;

        lu = s.ex_ld && s.ex_we && (s.ex_rd != 0) &&
             ((s.ex_rd == s.id_rs1) || (s.id_is_rs2 && s.ex_rd == s.id_rs2));
        if (rst) begin
            m_wait = 1'b0;
            m_owed = 0;
            m_sc   = 32'd0;
            m_fc   = 32'd0;
            e.en = 4'b0000; e.fl = 2'b11; e.fa = 2'b00; e.fb = 2'b00;
            e.sc = 32'd0;   e.fc = 32'd0;
        end else begin
            e.sc = m_sc;
            e.fc = m_fc;
            e.fa = ref_fwd(s.ex_rs1, s);
            e.fb = ref_fwd(s.ex_rs2, s);
            if (m_wait) begin
                e.en = 4'b0000; e.fl = 2'b00;
                if (s.rdy) m_wait = 1'b0;
            end else if (m_owed > 0) begin
                e.en = 4'b0011; e.fl = 2'b01;
                if (s.req && !s.rdy) m_wait = 1'b1;
                else m_owed = m_owed - 1;
            end else begin
                e.en = 4'b1111; e.fl = 2'b00;
                if (s.br) begin
                    e.fl = 2'b11;
                    if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
                end else if (lu) begin
                    e.en = 4'b0011; e.fl = 2'b01;
                end
                if (s.req && !s.rdy) m_wait = 1'b1;
                else if (!s.br && lu) m_owed = LOAD_LAT - 1;
            end
            if (!e.en[3] && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
        end
        sb.push_back(e);
        pushed++;
    endtask

    function automatic stim_t rnd();
        stim_t s;
        s.ex_rd     = 5'($urandom_range(0, 3));
        s.id_rs1    = ($urandom_range(0, 1) == 1) ? s.ex_rd : 5'($urandom_range(0, 3));
        s.id_rs2    = ($urandom_range(0, 1) == 1) ? s.ex_rd : 5'($urandom_range(0, 3));
        s.id_is_rs2 = 1'($urandom_range(0, 1));
        s.ex_rs1    = 5'($urandom_range(0, 3));
        s.ex_rs2    = 5'($urandom_range(0, 3));
        s.ex_we     = ($urandom_range(0, 3) != 0);
        s.ex_ld     = 1'($urandom_range(0, 1));
        s.br        = ($urandom_range(0, 9) == 0);
        s.mem_rd    = 5'($urandom_range(0, 3));
        s.mem_we    = 1'($urandom_range(0, 1));
        s.wb_rd     = 5'($urandom_range(0, 3));
        s.wb_we     = 1'($urandom_range(0, 1));
        s.req       = ($urandom_range(0, 3) == 0);
        s.rdy       = 1'($urandom_range(0, 1));
        return s;
    endfunction

    // Monitor: outputs are combinational, so compare mid-low-phase every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                popped++;
                chk("pc_en", {31'd0, pc_en_o}, {31'd0, e.en[3]});
                chk("id_en", {31'd0, id_en_o}, {31'd0, e.en[2]});
                chk("ex_en", {31'd0, ex_en_o}, {31'd0, e.en[1]});
                chk("mem_en", {31'd0, mem_en_o}, {31'd0, e.en[0]});
                chk("id_flush", {31'd0, id_flush_o}, {31'd0, e.fl[1]});
                chk("ex_flush", {31'd0, ex_flush_o}, {31'd0, e.fl[0]});
                chk("fwd_a", {30'd0, fwd_a_sel_o}, {30'd0, e.fa});
                chk("fwd_b", {30'd0, fwd_b_sel_o}, {30'd0, e.fb});
`ifdef HAZARD_PERF_EN
                chk("stall_cnt", stall_cnt_o, e.sc);
                chk("flush_cnt", flush_cnt_o, e.fc);
`endif
            end
        end
    end

    initial begin
        stim_t s;
        stim_t z;
        z = '0;
        reset_i = 1'b1;
        {id_rs1_addr_i, id_rs2_addr_i, id_is_rs2_i, ex_rs1_addr_i, ex_rs2_addr_i,
         ex_rd_addr_i, ex_rd_wren_i, ex_is_load_i, ex_br_taken_i, mem_rd_addr_i,
         mem_rd_wren_i, wb_rd_addr_i, wb_rd_wren_i, mem_req_i, mem_ready_i} = '0;

        // Held reset with live inputs: outputs must stay at reset values.
        for (int i = 0; i < 3; i++) step(rnd(), 1'b1);
        step(z, 1'b0);

        // Forwarding priority, then MEM rd = x0 falls through to WB.
        s = z; s.mem_rd = 5'd7; s.mem_we = 1; s.wb_rd = 5'd7; s.wb_we = 1;
        s.ex_rs1 = 5'd7; s.ex_rs2 = 5'd7;
        step(s, 1'b0);
        s.mem_rd = 5'd0;
        step(s, 1'b0);

        // Load-use on rs1 (x5).
        s = z; s.ex_ld = 1; s.ex_we = 1; s.ex_rd = 5'd5; s.id_rs1 = 5'd5;
        step(s, 1'b0);
        for (int i = 0; i < 3; i++) step(z, 1'b0);

        // rs2 match without id_is_rs2, then with it; load to x0.
        s = z; s.ex_ld = 1; s.ex_we = 1; s.ex_rd = 5'd5; s.id_rs1 = 5'd1; s.id_rs2 = 5'd5;
        step(s, 1'b0);
        s.id_is_rs2 = 1;
        step(s, 1'b0);
        for (int i = 0; i < 2; i++) step(z, 1'b0);
        s = z; s.ex_ld = 1; s.ex_we = 1; s.ex_rd = 5'd0; s.id_rs1 = 5'd0;
        step(s, 1'b0);

        // Taken branch with a simultaneous load-use.
        s = z; s.ex_ld = 1; s.ex_we = 1; s.ex_rd = 5'd5; s.id_rs1 = 5'd5; s.br = 1;
        step(s, 1'b0);
        for (int i = 0; i < 2; i++) step(z, 1'b0);

        // Memory wait during the last stall bubble.
        s = z; s.ex_ld = 1; s.ex_we = 1; s.ex_rd = 5'd5; s.id_rs1 = 5'd5;
        step(s, 1'b0);
        s = z; s.req = 1;
        for (int i = 0; i < 3; i++) step(s, 1'b0);
        s.rdy = 1;
        step(s, 1'b0);
        for (int i = 0; i < 3; i++) step(z, 1'b0);

        // Ready in the same cycle as the request: no wait.
        s = z; s.req = 1; s.rdy = 1;
        step(s, 1'b0);

        // Reset asserted mid-stall.
        s = z; s.ex_ld = 1; s.ex_we = 1; s.ex_rd = 5'd3; s.id_rs1 = 5'd3;
        step(s, 1'b0);
        step(z, 1'b1);
        step(z, 1'b1);
        for (int i = 0; i < 2; i++) step(z, 1'b0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) step(rnd(), ($urandom_range(0, 99) == 0));
        step(z, 1'b0);

        repeat (2) @(negedge clk);
        #5;
        chk("scoreboard_drained", popped, pushed);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
